hazard3_sync_filter: RTL and testbench
======================================

// Module: hazard3_sync_filter
//
// PURPOSE
// - Multi-channel input synchroniser with per-channel glitch filter and optional edge-pulse outputs.
// - Each bit of an asynchronous bus passes through an N_STAGES flop chain, then a stability counter.
// - A filtered output changes only after its synchronised input has disagreed for FILTER_CYCLES consecutive cycles.
// - Sits at the boundary for async inputs: debug halt request, external interrupts, JTAG-domain flags into the DM.
//
// PARAMETERS
// - W             1  number of independent channels
// - N_STAGES      2  synchroniser depth per channel; must be >= 2
// - FILTER_CYCLES 0  consecutive disagreeing cycles needed to update o; 0 = filter bypassed
// - RESET_VAL     0  W-bit reset value of synchroniser flops, o, and edge-history register
//
// PORTS
// - clk     in   1  sole clock; all state updates on posedge
// - rst_n   in   1  asynchronous active-low reset
// - i       in   W  asynchronous inputs, one per channel
// - o       out  W  synchronised, filtered level per channel
// - o_rise  out  W  one-cycle pulse when o[k] goes 0->1
// - o_fall  out  W  one-cycle pulse when o[k] goes 1->0
//
// BEHAVIOUR
// - Clocking and reset: single clock clk; reset rst_n is asynchronous and active-low.
// - Reset values: sync chain bits = RESET_VAL[k]; o = RESET_VAL; filter counters = 0; o_rise = o_fall = 0.
// - Synchroniser: per channel, shift {chain[N_STAGES-2:0], i[k]} each cycle; s[k] = chain[N_STAGES-1].
// - Synchroniser flops carry the codebase keep attribute so they are never retimed or merged.
// - Filter, FILTER_CYCLES == 0: o[k] = s[k] (no counter logic generated); latency from i to o is N_STAGES cycles.
// - Filter, FILTER_CYCLES > 0: per-channel counter cnt, width $clog2(FILTER_CYCLES+1), updated each cycle:
//   - s == o: cnt <= 0
//   - s != o and cnt == FILTER_CYCLES-1: o <= s, cnt <= 0
//   - s != o otherwise: cnt <= cnt + 1
// - Counter never wraps; its maximum value is FILTER_CYCLES-1.
// - Filtered latency: i change -> o change = N_STAGES + FILTER_CYCLES cycles, for inputs held stable.
// - Glitch rejection: s pulse of length L < FILTER_CYCLES leaves o unchanged and cnt returns to 0.
// - Chatter: each cycle with s == o restarts the count, so alternating s never updates o (FILTER_CYCLES >= 2).
// - Channels are fully independent; simultaneous transitions on several channels are each handled by their own counter.
// - Reset mid-count: all counters clear; o returns to RESET_VAL asynchronously; no edge pulse is produced by reset.
// - After reset release, if i differs from RESET_VAL, o updates after N_STAGES + FILTER_CYCLES cycles with a normal edge pulse.
//
// CONFIGURATION
// - Macro HAZARD3_SYNC_FILTER_EDGE_EN:
//   - Defined: history reg o_prev (reset RESET_VAL) samples o each cycle.
//   - o_rise = o & ~o_prev; o_fall = ~o & o_prev.
//   - Each pulse is high for exactly the first cycle o holds its new value.
//   - Edges are derived from o, so they are filtered too.
//   - Not defined: o_rise and o_fall are tied to W'b0; o_prev is not instantiated.
//   - Ports remain present, so instantiations are identical in both builds.
//
// TESTING
// - W=1, N_STAGES=2, FILTER=0: raise i at edge 0 -> o=1 sampled at edge 2; with EDGE_EN, o_rise=1 for that one cycle only.
// - W=1, FILTER=4: i high for 3 cycles -> o stays 0, no o_rise; i high for 4 cycles -> o=1 at edge N_STAGES+4, one o_rise pulse.
// - W=4, FILTER=3: i toggles every cycle for 20 cycles -> o, o_rise, o_fall remain 0 throughout.
// - W=4, FILTER=2: i 4'b0000 -> 4'b1010 in one cycle -> o=4'b1010 after 4 cycles; o_rise=4'b1010 once; o_fall=0.
// - RESET_VAL=1, FILTER=5: hold i=0, drop rst_n when cnt=3 -> o asserts 1 immediately, cnt=0, no pulse; after release, o falls after 7 cycles.
// - Build without HAZARD3_SYNC_FILTER_EDGE_EN, repeat the W=4 case -> o identical; o_rise and o_fall stay 0 at all times.

Source files
------------

// File: rtl/hazard3_sync_filter.sv
// hazard3_sync_filter: multi-channel async input synchroniser with a
// per-channel glitch filter and optional edge-pulse outputs.
//
// Parameters:
//   W             number of independent channels
//   N_STAGES      synchroniser depth per channel (>= 2)
//   FILTER_CYCLES consecutive disagreeing cycles needed to move o (0 = bypass)
//   RESET_VAL     reset value of sync flops, o and the edge history
//
// Ports:
//   clk     sole clock, all state updates on posedge
//   rst_n   asynchronous active-low reset
//   i       asynchronous inputs, one per channel
//   o       synchronised, filtered level per channel
//   o_rise  one-cycle pulse when o[k] goes 0->1
//   o_fall  one-cycle pulse when o[k] goes 1->0
//
// Build option: define HAZARD3_SYNC_FILTER_EDGE_EN to enable o_rise/o_fall.
// Without it both are tied low but the ports stay present.

module hazard3_sync_filter #(
    parameter int unsigned    W             = 1,
    parameter int unsigned    N_STAGES      = 2,
    parameter int unsigned    FILTER_CYCLES = 0,
    parameter logic [W-1:0]   RESET_VAL     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i,
    output logic [W-1:0] o,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    if (N_STAGES < 2) begin : g_bad_depth
        $error("hazard3_sync_filter: N_STAGES must be >= 2");
    end

    logic [W-1:0] s;

    for (genvar k = 0; k < W; k++) begin : g_ch

        // Metastability chain; must never be retimed or merged.
        (* keep = "true" *) logic [N_STAGES-1:0] chain;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chain <= {N_STAGES{RESET_VAL[k]}};
            end else begin
                chain <= {chain[N_STAGES-2:0], i[k]};
            end
        end

        assign s[k] = chain[N_STAGES-1];

        if (FILTER_CYCLES == 0) begin : g_bypass
            assign o[k] = s[k];
        end else begin : g_filt
            localparam int unsigned CW = $clog2(FILTER_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          o_q;

            // Count consecutive cycles where s disagrees with o; any
            // agreeing cycle restarts the count, so chatter never lands.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                    o_q <= RESET_VAL[k];
                end else if (s[k] == o_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    cnt <= '0;
                    o_q <= s[k];
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign o[k] = o_q;
        end
    end

`ifdef HAZARD3_SYNC_FILTER_EDGE_EN
    logic [W-1:0] o_prev;

    // Reset also clears the history to RESET_VAL, so reset never pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_prev <= RESET_VAL;
        end else begin
            o_prev <= o;
        end
    end

    assign o_rise = o & ~o_prev;
    assign o_fall = ~o & o_prev;
`else
    assign o_rise = '0;
    assign o_fall = '0;
`endif

endmodule

// File: tb/tb_hazard3_sync_filter.sv
// tb_hazard3_sync_filter: scoreboard bench for hazard3_sync_filter,
// five configurations driven in lockstep against a run-length model.

module tb_hazard3_sync_filter;

`ifdef HAZARD3_SYNC_FILTER_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    localparam int NI = 5;
    localparam int NC = 121;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [0:0] i0, o0, r0, f0;
    logic [0:0] i1, o1, r1, f1;
    logic [3:0] i2, o2, r2, f2;
    logic [3:0] i3, o3, r3, f3;
    logic [0:0] i4, o4, r4, f4;

    hazard3_sync_filter #(
        .W(1), .N_STAGES(2), .FILTER_CYCLES(0), .RESET_VAL(1'b0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .i(i0),
        .o(o0), .o_rise(r0), .o_fall(f0)
    );

    hazard3_sync_filter #(
        .W(1), .N_STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(1'b0)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .i(i1),
        .o(o1), .o_rise(r1), .o_fall(f1)
    );

    hazard3_sync_filter #(
        .W(4), .N_STAGES(2), .FILTER_CYCLES(3), .RESET_VAL(4'h0)
    ) u2 (
        .clk(clk), .rst_n(rst_n), .i(i2),
        .o(o2), .o_rise(r2), .o_fall(f2)
    );

    hazard3_sync_filter #(
        .W(4), .N_STAGES(2), .FILTER_CYCLES(2), .RESET_VAL(4'h0)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .i(i3),
        .o(o3), .o_rise(r3), .o_fall(f3)
    );

    hazard3_sync_filter #(
        .W(1), .N_STAGES(2), .FILTER_CYCLES(5), .RESET_VAL(1'b1)
    ) u4 (
        .clk(clk), .rst_n(rst_n), .i(i4),
        .o(o4), .o_rise(r4), .o_fall(f4)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    int         fp [NI]  = '{0, 4, 3, 2, 5};
    logic [3:0] rvp[NI]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
    logic [3:0] wm [NI]  = '{4'h1, 4'h1, 4'hF, 4'hF, 4'h1};

    logic [3:0] m_p1[NI], m_p2[NI], m_o[NI], m_op[NI], m_rv[NI];
    int         m_rl[NI][4];
    logic [3:0] iv  [NI];

    logic [59:0] sbq[$];

    function automatic logic [11:0] mk_exp(input int n);
        logic [3:0] r, f;
        r = EDGE ? (m_o[n] & ~m_op[n]) : 4'h0;
        f = EDGE ? (~m_o[n] & m_op[n] & wm[n]) : 4'h0;
        return {m_o[n], r, f};
    endfunction

    function automatic logic [11:0] got(input int n);
        logic [11:0] g;
        g = '0;
        case (n)
            0: g = {3'b0, o0, 3'b0, r0, 3'b0, f0};
            1: g = {3'b0, o1, 3'b0, r1, 3'b0, f1};
            2: g = {o2, r2, f2};
            3: g = {o3, r3, f3};
            default: g = {3'b0, o4, 3'b0, r4, 3'b0, f4};
        endcase
        return g;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < NI; n++) begin
            m_p1[n] = rvp[n] & wm[n];
            m_p2[n] = rvp[n] & wm[n];
            m_o[n]  = rvp[n] & wm[n];
            m_op[n] = rvp[n] & wm[n];
            m_rv[n] = rvp[n] & wm[n];
            for (int b = 0; b < 4; b++) m_rl[n][b] = 0;
        end
    endtask

    // o follows a run of identical synchronised values once that run
    // has lasted fp cycles; with fp == 0 o is the synchroniser output.
    task automatic model_step(input int n, input logic [3:0] v);
        logic [3:0] s_old, o_old, o_new;
        s_old = m_p2[n];
        o_old = m_o[n];
        m_p2[n] = m_p1[n];
        m_p1[n] = v & wm[n];
        o_new = o_old;
        for (int b = 0; b < 4; b++) begin
            if (s_old[b] === m_rv[n][b]) begin
                if (m_rl[n][b] < 1000) m_rl[n][b]++;
            end else begin
                m_rv[n][b] = s_old[b];
                m_rl[n][b] = 1;
            end
            if (fp[n] != 0 && m_rl[n][b] >= fp[n] &&
                s_old[b] != o_old[b])
                o_new[b] = s_old[b];
        end
        if (fp[n] == 0) o_new = m_p2[n];
        m_op[n] = o_old;
        m_o[n]  = o_new;
    endtask

    logic [11:0] quiet1, quiet2;

    task automatic directed(input int le);
        if (le >= 10 && le <= 29) quiet1 |= got(1);
        if (le >= 10 && le <= 45) quiet2 |= got(2);
        if (le == 10) chk("u0_lat", got(0), 12'h000);
        if (le == 11)
            chk("u0_rise", got(0), {4'h1, (EDGE ? 4'h1 : 4'h0), 4'h0});
        if (le == 12) chk("u0_pulse1", got(0), 12'h100);
        if (le == 34) chk("u1_hold", got(1), 12'h000);
        if (le == 35)
            chk("u1_rise", got(1), {4'h1, (EDGE ? 4'h1 : 4'h0), 4'h0});
        if (le == 22) chk("u3_hold", got(3), 12'h000);
        if (le == 23)
            chk("u3_rise", got(3), {4'hA, (EDGE ? 4'hA : 4'h0), 4'h0});
        if (le == 24) chk("u3_pulse1", got(3), 12'hA00);
        if (le == 14) chk("u4_hold", got(4), 12'h100);
        if (le == 15)
            chk("u4_fall", got(4), (EDGE ? 12'h001 : 12'h000));
    endtask

    task automatic pick(input int c, output logic rst);
        rst = !(c < 2 || c == 7 || c == 8 || c == 90);
        if (c < 60) begin
            iv[0] = 4'((c >= 10 && c < 30));
            iv[1] = 4'((c >= 10 && c < 13) || (c >= 30 && c < 34));
            if (c >= 10 && c < 30) iv[2] = c[0] ? 4'hF : 4'h0;
            else if (c == 40 || c == 41) iv[2] = 4'h5;
            else iv[2] = 4'h0;
            iv[3] = (c >= 50) ? 4'b0110 : (c >= 20) ? 4'b1010 : 4'h0;
            iv[4] = 4'h0;
        end else begin
            for (int n = 0; n < NI; n++)
                if ($urandom_range(3) == 0)
                    iv[n] = 4'($urandom) & wm[n];
        end
    endtask

    task automatic compare_pop(input int le);
        logic [59:0] e;
        e = sbq.pop_front();
        for (int n = 0; n < NI; n++)
            chk($sformatf("u%0d_e%0d", n, le), got(n), e[n*12 +: 12]);
        directed(le);
    endtask

    initial begin
        logic        rst;
        logic [59:0] e;
        quiet1 = '0;
        quiet2 = '0;
        rst_n = 1'b0;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0; i4 = '0;
        for (int n = 0; n < NI; n++) iv[n] = 4'h0;
        model_reset();
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            if (sbq.size() != 0) compare_pop(c - 1);
            pick(c, rst);
            rst_n = rst;
            i0 = iv[0][0];
            i1 = iv[1][0];
            i2 = iv[2];
            i3 = iv[3];
            i4 = iv[4][0];
            if (!rst) begin
                model_reset();
                #1;
                for (int n = 0; n < NI; n++)
                    chk($sformatf("rst_u%0d_c%0d", n, c), got(n), mk_exp(n));
                if (c == 7) chk("u4_rst_async", got(4), 12'h100);
            end else begin
                for (int n = 0; n < NI; n++) model_step(n, iv[n]);
            end
            for (int n = 0; n < NI; n++) e[n*12 +: 12] = mk_exp(n);
            sbq.push_back(e);
        end
        @(negedge clk);
        if (sbq.size() != 0) compare_pop(NC - 1);
        chk("u1_glitch_quiet", quiet1, 12'h000);
        chk("u2_chatter_quiet", quiet2, 12'h000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
